// File: rtl/rv32i_cpu_top.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_cpu_top (with rv32i_inst_mem)
// Brief    : Single-cycle RV32I integer core, no load/store, private ROM.
// Revision : 1.0 - initial release
// ============================================================================

module rv32i_inst_mem #(
    parameter int IMEM_DEPTH = 1024,
    parameter int ADDR_W     = 10
) (
    input  logic [ADDR_W-1:0] i_addr,
    output logic [31:0]       o_rdata
);
    // Contents are loaded externally before reset release.
    logic [31:0] mem [IMEM_DEPTH];

    assign o_rdata = mem[i_addr];
endmodule

module rv32i_cpu_top #(
    parameter int          IMEM_DEPTH = 1024,
    parameter logic [31:0] RESET_PC   = 32'h00000000
) (
    input  logic clk,
    input  logic rst_n
);
    localparam int         c_ADDR_W    = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_REG    = 7'b0110011;
    localparam logic [6:0] c_F7_BASE   = 7'b0000000;
    localparam logic [6:0] c_F7_ALT    = 7'b0100000;

    logic [31:0] pc_current_s1;
    logic [31:0] r_regs [32];

    logic [31:0] w_inst;
    logic [6:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [6:0]  w_funct7;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    logic [31:0] w_rs1_val;
    logic [31:0] w_rs2_val;
    logic [31:0] w_pc_plus4;
    logic        w_imm_legal;
    logic        w_reg_legal;
    logic        w_take;
    logic        w_wr_en;
    logic [31:0] w_wr_data;
    logic [31:0] w_pc_next;

    rv32i_inst_mem #(
        .IMEM_DEPTH (IMEM_DEPTH),
        .ADDR_W     (c_ADDR_W)
    ) u_inst_mem_s1 (
        .i_addr  (pc_current_s1[c_ADDR_W+1:2]),
        .o_rdata (w_inst)
    );

    assign w_opcode = w_inst[6:0];
    assign w_rd     = w_inst[11:7];
    assign w_funct3 = w_inst[14:12];
    assign w_rs1    = w_inst[19:15];
    assign w_rs2    = w_inst[24:20];
    assign w_funct7 = w_inst[31:25];

    assign w_imm_i = {{20{w_inst[31]}}, w_inst[31:20]};
    assign w_imm_b = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
    assign w_imm_u = {w_inst[31:12], 12'b0};
    assign w_imm_j = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};

    assign w_rs1_val  = (w_rs1 == 5'd0) ? 32'd0 : r_regs[w_rs1];
    assign w_rs2_val  = (w_rs2 == 5'd0) ? 32'd0 : r_regs[w_rs2];
    assign w_pc_plus4 = pc_current_s1 + 32'd4;

    // Shift-immediate forms reserve funct7; only SRAI may set the alternate bit.
    assign w_imm_legal = ((w_funct3 != 3'b001) || (w_funct7 == c_F7_BASE)) &&
                         ((w_funct3 != 3'b101) || (w_funct7 == c_F7_BASE) || (w_funct7 == c_F7_ALT));
    assign w_reg_legal = (w_funct7 == c_F7_BASE) ||
                         ((w_funct7 == c_F7_ALT) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)));

    function automatic logic [31:0] f_alu(
        input logic [2:0]  funct3,
        input logic        alt,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [31:0] res;
        case (funct3)
            3'b000:  res = alt ? (a - b) : (a + b);
            3'b001:  res = a << b[4:0];
            3'b010:  res = {31'd0, ($signed(a) < $signed(b))};
            3'b011:  res = {31'd0, (a < b)};
            3'b100:  res = a ^ b;
            3'b101:  res = alt ? $unsigned($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            3'b110:  res = a | b;
            default: res = a & b;
        endcase
        return res;
    endfunction

    always_comb begin
        w_take    = 1'b0;
        w_wr_en   = 1'b0;
        w_wr_data = 32'd0;
        w_pc_next = w_pc_plus4;
        case (w_opcode)
            c_OP_LUI: begin
                w_wr_en   = 1'b1;
                w_wr_data = w_imm_u;
            end
            c_OP_AUIPC: begin
                w_wr_en   = 1'b1;
                w_wr_data = pc_current_s1 + w_imm_u;
            end
            c_OP_JAL: begin
                w_wr_en   = 1'b1;
                w_wr_data = w_pc_plus4;
                w_pc_next = pc_current_s1 + w_imm_j;
            end
            c_OP_JALR: begin
                if (w_funct3 == 3'b000) begin
                    w_wr_en   = 1'b1;
                    w_wr_data = w_pc_plus4;
                    w_pc_next = (w_rs1_val + w_imm_i) & ~32'd1;
                end
            end
            c_OP_BRANCH: begin
                case (w_funct3)
                    3'b000:  w_take = (w_rs1_val == w_rs2_val);
                    3'b001:  w_take = (w_rs1_val != w_rs2_val);
                    3'b100:  w_take = ($signed(w_rs1_val) <  $signed(w_rs2_val));
                    3'b101:  w_take = ($signed(w_rs1_val) >= $signed(w_rs2_val));
                    3'b110:  w_take = (w_rs1_val <  w_rs2_val);
                    3'b111:  w_take = (w_rs1_val >= w_rs2_val);
                    default: w_take = 1'b0;
                endcase
                if (w_take) begin
                    w_pc_next = pc_current_s1 + w_imm_b;
                end
            end
            c_OP_IMM: begin
                if (w_imm_legal) begin
                    w_wr_en   = 1'b1;
                    w_wr_data = f_alu(w_funct3, (w_funct3 == 3'b101) && w_funct7[5],
                                      w_rs1_val, w_imm_i);
                end
            end
            c_OP_REG: begin
                if (w_reg_legal) begin
                    w_wr_en   = 1'b1;
                    w_wr_data = f_alu(w_funct3, w_funct7[5], w_rs1_val, w_rs2_val);
                end
            end
            default: begin
            end
        endcase
    end

    // Reads above see the pre-edge register values, so rd==rs1 is safe.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            pc_current_s1 <= RESET_PC;
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else begin
            pc_current_s1 <= w_pc_next;
            if (w_wr_en && (w_rd != 5'd0)) begin
                r_regs[w_rd] <= w_wr_data;
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_rv32i_cpu_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32i_cpu_top
// Brief    : Directed vector table, NOP/reset sequences and random ISS compare.
// Revision : 1.0 - initial release
// ============================================================================

module tb_rv32i_cpu_top;
    localparam int c_DEPTH = 1024;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rv32i_cpu_top #(
        .IMEM_DEPTH (c_DEPTH),
        .RESET_PC   (32'h00000000)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n)
    );

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] m_mem [c_DEPTH];
    logic [31:0] m_x   [32];
    logic [31:0] m_pc;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] inst;
        int          chk_reg;
        logic [31:0] exp_val;
        logic [31:0] exp_pc;
    } vec_t;
    vec_t tbl [16];

    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [31:0] rs1,
                                          input logic [31:0] f3, input logic [31:0] rd,
                                          input logic [31:0] op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction

    function automatic logic [31:0] enc_r(input logic [31:0] f7, input logic [31:0] rs2,
                                          input logic [31:0] rs1, input logic [31:0] f3,
                                          input logic [31:0] rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [31:0] rs2,
                                          input logic [31:0] rs1, input logic [31:0] f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [31:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_u(input logic [31:0] imm, input logic [31:0] rd,
                                          input logic [31:0] op);
        return {imm[19:0], rd[4:0], op[6:0]};
    endfunction

    function automatic logic lt_s(input logic [31:0] a, input logic [31:0] b);
        return (a ^ 32'h80000000) < (b ^ 32'h80000000);
    endfunction

    function automatic logic [31:0] sra(input logic [31:0] a, input logic [4:0] sh);
        return (a >> sh) | (a[31] ? ~(32'hFFFFFFFF >> sh) : 32'd0);
    endfunction

    // Architectural reference: interprets one instruction word on the model state.
    task automatic iss_step();
        logic [31:0] w, a, b, ii, res, nxt;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic [4:0]  sh;
        logic        wr;
        w   = m_mem[(m_pc >> 2) % c_DEPTH];
        op  = w[6:0];
        f3  = w[14:12];
        f7  = w[31:25];
        sh  = w[24:20];
        a   = m_x[w[19:15]];
        b   = m_x[w[24:20]];
        ii  = {{20{w[31]}}, w[31:20]};
        nxt = m_pc + 32'd4;
        res = 32'd0;
        wr  = 1'b0;
        case (op)
            7'h37: begin wr = 1'b1; res = {w[31:12], 12'd0}; end
            7'h17: begin wr = 1'b1; res = m_pc + {w[31:12], 12'd0}; end
            7'h6f: begin
                wr  = 1'b1;
                res = m_pc + 32'd4;
                nxt = m_pc + {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            end
            7'h67: if (f3 == 3'd0) begin
                wr  = 1'b1;
                res = m_pc + 32'd4;
                nxt = (a + ii) & 32'hFFFFFFFE;
            end
            7'h63: begin
                logic take;
                case (f3)
                    3'd0:    take = (a == b);
                    3'd1:    take = (a != b);
                    3'd4:    take = lt_s(a, b);
                    3'd5:    take = !lt_s(a, b);
                    3'd6:    take = (a < b);
                    3'd7:    take = !(a < b);
                    default: take = 1'b0;
                endcase
                if (take)
                    nxt = m_pc + {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            end
            7'h13: begin
                wr = 1'b1;
                case (f3)
                    3'd0: res = a + ii;
                    3'd2: res = {31'd0, lt_s(a, ii)};
                    3'd3: res = {31'd0, a < ii};
                    3'd4: res = a ^ ii;
                    3'd6: res = a | ii;
                    3'd7: res = a & ii;
                    3'd1: if (f7 == 7'h00) res = a << sh; else wr = 1'b0;
                    default: begin
                        if (f7 == 7'h00)      res = a >> sh;
                        else if (f7 == 7'h20) res = sra(a, sh);
                        else                  wr = 1'b0;
                    end
                endcase
            end
            7'h33: begin
                wr = 1'b1;
                case ({f7, f3})
                    {7'h00, 3'd0}: res = a + b;
                    {7'h20, 3'd0}: res = a - b;
                    {7'h00, 3'd1}: res = a << b[4:0];
                    {7'h00, 3'd2}: res = {31'd0, lt_s(a, b)};
                    {7'h00, 3'd3}: res = {31'd0, a < b};
                    {7'h00, 3'd4}: res = a ^ b;
                    {7'h00, 3'd5}: res = a >> b[4:0];
                    {7'h20, 3'd5}: res = sra(a, b[4:0]);
                    {7'h00, 3'd6}: res = a | b;
                    {7'h00, 3'd7}: res = a & b;
                    default:       wr = 1'b0;
                endcase
            end
            default: wr = 1'b0;
        endcase
        if (wr && (w[11:7] != 5'd0)) m_x[w[11:7]] = res;
        m_pc = nxt;
    endtask

    function automatic logic [31:0] gen_inst();
        int k, rd, r1, r2, f3;
        logic [31:0] imm, f7;
        k   = $urandom_range(0, 99);
        rd  = $urandom_range(0, 7);
        r1  = $urandom_range(0, 7);
        r2  = $urandom_range(0, 7);
        f3  = $urandom_range(0, 7);
        imm = $urandom();
        if (k < 8)  return enc_u(imm, rd, 32'h37);
        if (k < 12) return enc_u(imm, rd, 32'h17);
        if (k < 40) begin
            if (f3 == 1)      imm = imm & 32'h1f;
            else if (f3 == 5) imm = (imm & 32'h1f) | (($urandom_range(0, 1) == 1) ? 32'h400 : 32'h0);
            return enc_i(imm, r1, f3, rd, 32'h13);
        end
        if (k < 70) begin
            f7 = (((f3 == 0) || (f3 == 5)) && ($urandom_range(0, 1) == 1)) ? 32'h20 : 32'h0;
            return enc_r(f7, r2, r1, f3, rd);
        end
        if (k < 82) return enc_b(4 * $urandom_range(1, 6), r2, r1, f3);
        if (k < 86) return enc_j(4 * $urandom_range(1, 4), rd);
        if (k < 89) return enc_i(imm, r1, 0, rd, 32'h67);
        if (k < 95) begin
            case ($urandom_range(0, 3))
                0:       return (imm & 32'hFFFFFF80) | 32'h03;
                1:       return (imm & 32'hFFFFFF80) | 32'h23;
                2:       return (imm & 32'hFFFFFF80) | 32'h0f;
                default: return (imm & 32'hFFFFFF80) | 32'h73;
            endcase
        end
        return $urandom();
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, got, want);
        end
    endtask

    task automatic chk_regs(input string nm);
        int bad;
        bad = -1;
        n_vec++;
        for (int i = 0; i < 32; i++)
            if ((bad < 0) && (u_dut.r_regs[i] !== m_x[i])) bad = i;
        if (bad >= 0) begin
            n_bad++;
            $display("FAIL %s: x%0d got %h, want %h", nm, bad, u_dut.r_regs[bad], m_x[bad]);
        end
    endtask

    task automatic load_word(input int idx, input logic [31:0] w);
        u_dut.u_inst_mem_s1.mem[idx] = w;
        m_mem[idx] = w;
    endtask

    logic [31:0] nops [8];

    initial begin
        tbl[0]  = '{32'h00, enc_i(-1, 0, 0, 1, 32'h13),        1, 32'hFFFFFFFF, 32'h04};
        tbl[1]  = '{32'h04, enc_i(28, 1, 5, 2, 32'h13),        2, 32'h0000000F, 32'h08};
        tbl[2]  = '{32'h08, enc_u(1, 5, 32'h17),               5, 32'h00001008, 32'h0C};
        tbl[3]  = '{32'h0C, enc_i(32'h404, 1, 5, 3, 32'h13),   3, 32'hFFFFFFFF, 32'h10};
        tbl[4]  = '{32'h10, enc_j(8, 1),                       1, 32'h00000014, 32'h18};
        tbl[5]  = '{32'h18, enc_r(0, 1, 0, 3, 4),              4, 32'h00000001, 32'h1C};
        tbl[6]  = '{32'h1C, enc_i(5, 0, 0, 0, 32'h13),         0, 32'h00000000, 32'h20};
        tbl[7]  = '{32'h20, enc_i(1, 8, 0, 8, 32'h13),         8, 32'h00000001, 32'h24};
        tbl[8]  = '{32'h24, enc_u(32'h80000, 6, 32'h37),       6, 32'h80000000, 32'h28};
        tbl[9]  = '{32'h28, enc_i(32'h20, 0, 0, 7, 32'h13),    7, 32'h00000020, 32'h2C};
        tbl[10] = '{32'h2C, enc_i(-1, 0, 0, 1, 32'h13),        1, 32'hFFFFFFFF, 32'h30};
        tbl[11] = '{32'h30, enc_i(1, 0, 0, 2, 32'h13),         2, 32'h00000001, 32'h34};
        tbl[12] = '{32'h34, enc_b(8, 2, 1, 5),                 1, 32'hFFFFFFFF, 32'h38};
        tbl[13] = '{32'h38, enc_i(3, 7, 0, 0, 32'h67),         0, 32'h00000000, 32'h22};
        tbl[14] = '{32'h22, enc_i(1, 8, 0, 8, 32'h13),         8, 32'h00000002, 32'h26};
        tbl[15] = '{32'h26, enc_u(32'h80000, 6, 32'h37),       6, 32'h80000000, 32'h2A};

        // ---- power-on reset and directed table ----
        for (int i = 0; i < c_DEPTH; i++) load_word(i, 32'd0);
        for (int i = 0; i < 16; i++) load_word(int'(tbl[i].addr >> 2), tbl[i].inst);
        load_word(5, enc_i(1, 0, 0, 9, 32'h13));
        for (int i = 0; i < 32; i++) m_x[i] = 32'd0;
        #1 rst_n = 1'b1;
        #1;
        chk("reset_pc", u_dut.pc_current_s1, 32'h0);
        chk_regs("reset_regs");
        @(posedge clk); #1;
        chk("reset_hold_pc", u_dut.pc_current_s1, 32'h0);
        @(negedge clk) rst_n = 1'b0;

        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            chk($sformatf("vec%0d_x%0d", i, tbl[i].chk_reg), u_dut.r_regs[tbl[i].chk_reg], tbl[i].exp_val);
            chk($sformatf("vec%0d_pc", i), u_dut.pc_current_s1, tbl[i].exp_pc);
        end
        chk("jal_skipped_x9", u_dut.r_regs[9], 32'h0);

        // ---- asynchronous reset mid-program ----
        @(negedge clk); #2 rst_n = 1'b1;
        #1;
        chk("midrst_pc_async", u_dut.pc_current_s1, 32'h0);
        chk_regs("midrst_regs_async");
        @(posedge clk); #1;
        chk("midrst_pc_held", u_dut.pc_current_s1, 32'h0);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_first_pc", u_dut.pc_current_s1, 32'h4);
        chk("midrst_first_x1", u_dut.r_regs[1], 32'hFFFFFFFF);

        // ---- NOP-class instructions ----
        @(negedge clk) rst_n = 1'b1;
        load_word(0, enc_i(32'h55, 0, 0, 1, 32'h13));
        load_word(1, enc_i(32'h77, 0, 0, 10, 32'h13));
        load_word(2, enc_i(32'h66, 0, 0, 11, 32'h13));
        nops[0] = enc_i(4, 1, 2, 10, 32'h03);
        nops[1] = {7'd0, 5'd1, 5'd0, 3'b010, 5'd0, 7'b0100011};
        nops[2] = 32'h00000073;
        nops[3] = enc_i(32'h300, 1, 1, 11, 32'h73);
        nops[4] = 32'h00100073;
        nops[5] = 32'hFFFFFFFF;
        nops[6] = 32'h0FF0000F;
        nops[7] = enc_r(1, 1, 1, 0, 10);
        for (int i = 0; i < 8; i++) load_word(3 + i, nops[i]);
        for (int i = 0; i < 32; i++) m_x[i] = 32'd0;
        m_x[1] = 32'h55; m_x[10] = 32'h77; m_x[11] = 32'h66;
        @(negedge clk) rst_n = 1'b0;
        repeat (3) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk($sformatf("nop%0d_pc", i), u_dut.pc_current_s1, 32'((4 + i) * 4));
            chk_regs($sformatf("nop%0d_regs", i));
        end

        // ---- randomized program against the reference model ----
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < c_DEPTH; i++) load_word(i, gen_inst());
        for (int i = 0; i < 32; i++) m_x[i] = 32'd0;
        m_pc = 32'd0;
        @(negedge clk) rst_n = 1'b0;
        for (int s = 0; s < 600; s++) begin
            @(posedge clk); #1;
            iss_step();
            chk($sformatf("rnd%0d_pc", s), u_dut.pc_current_s1, m_pc);
            chk_regs($sformatf("rnd%0d_regs", s));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

`default_nettype wire
